// File: rtl/sad_pkg.sv
// Shared definitions for the partial-parallel SAD block: FSM state encoding,
// result/lane-sum width helpers and the candidate index width.
package sad_pkg;

    // Width of the candidate index reported by the optional minimum tracker
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } sad_state_t;

    // Block SAD width: worst case is BLOCK * (2^WIDTH - 1), which always fits
    function automatic int sad_w(input int width, input int block);
        return width + $clog2(block);
    endfunction

    // Width of one beat's lane sum: LANES * (2^WIDTH - 1) fits exactly
    function automatic int lane_w(input int width, input int lanes);
        return width + $clog2(lanes);
    endfunction

endpackage

// File: rtl/sad_lane_tree.sv
// Combinational |a-b| for every lane followed by a binary adder tree.
// Nodes are heap-indexed: leaves at LANES..2*LANES-1, root at 1.
module sad_lane_tree
    import sad_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic [LANES*WIDTH-1:0]           a,
    input  logic [LANES*WIDTH-1:0]           b,
    output logic [lane_w(WIDTH, LANES)-1:0]  sum
);

    localparam int LW = lane_w(WIDTH, LANES);

    logic [LW-1:0] node [1:2*LANES-1];

    for (genvar k = 0; k < LANES; k++) begin : g_leaf
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] diff;
        assign pa   = a[k*WIDTH +: WIDTH];
        assign pb   = b[k*WIDTH +: WIDTH];
        assign diff = (pa >= pb) ? (pa - pb) : (pb - pa);
        assign node[LANES+k] = LW'(diff);
    end

    // Each internal node adds its two children; LW bits never overflow
    for (genvar n = 1; n < LANES; n++) begin : g_node
        assign node[n] = node[2*n] + node[2*n+1];
    end

    assign sum = node[1];

endmodule

// File: rtl/sad_partial_par.sv
// Partial-parallel sum of absolute differences over one block of BLOCK
// pixels, LANES pixel pairs per loaded beat. Stage 1 registers the beat's
// lane sum, stage 2 folds it into the block accumulator.
// Optional feature: define SAD_MIN_TRACK_EN to add a running minimum-SAD
// tracker (ports min_clr, out_min_sad, out_min_idx).
module sad_partial_par
    import sad_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int BLOCK = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            init,
    input  logic                            loaded,
    input  logic                            ack,
    input  logic [LANES*WIDTH-1:0]          ori,
    input  logic [LANES*WIDTH-1:0]          can,
`ifdef SAD_MIN_TRACK_EN
    input  logic                            min_clr,
    output logic [sad_w(WIDTH, BLOCK)-1:0]  out_min_sad,
    output logic [IDX_W-1:0]                out_min_idx,
`endif
    output logic                            out_ready,
    output logic                            out_done,
    output logic [sad_w(WIDTH, BLOCK)-1:0]  out_sad
);

    localparam int SAD_W = sad_w(WIDTH, BLOCK);
    localparam int LW    = lane_w(WIDTH, LANES);
    localparam int BEATS = BLOCK / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    sad_state_t        state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [LW-1:0]     lane_sum;
    logic [LW-1:0]     lane_sum_p1;
    logic              vld_p1;
    logic [SAD_W-1:0]  acc_p2;
    logic [SAD_W-1:0]  acc_nxt;
    logic              take;
    logic              last_beat;

    sad_lane_tree #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_tree (
        .a   (ori),
        .b   (can),
        .sum (lane_sum)
    );

    assign take      = (state == ACC) && loaded;
    assign last_beat = take && (beat_cnt == LAST);
    assign acc_nxt   = acc_p2 + SAD_W'(lane_sum_p1);
    assign out_sad   = acc_p2;

    // Next-state and handshake outputs; init restarts from any state
    always_comb begin
        state_nxt = state;
        out_ready = 1'b0;
        out_done  = 1'b0;
        case (state)
            IDLE:    state_nxt = IDLE;
            ACC: begin
                out_ready = 1'b1;
                if (last_beat) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = DONE;
            DONE: begin
                out_done = 1'b1;
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (init) state_nxt = ACC;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Stage 1 capture of the lane sum and stage 2 accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt    <= '0;
            lane_sum_p1 <= '0;
            vld_p1      <= 1'b0;
            acc_p2      <= '0;
        end else if (init) begin
            beat_cnt <= '0;
            vld_p1   <= 1'b0;
            acc_p2   <= '0;
        end else begin
            vld_p1 <= take;
            if (take) begin
                lane_sum_p1 <= lane_sum;
                beat_cnt    <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (vld_p1) acc_p2 <= acc_nxt;
        end
    end

`ifdef SAD_MIN_TRACK_EN
    logic             done_entry;
    logic             min_vld;
    logic [IDX_W-1:0] cand_idx;
    logic [SAD_W-1:0] sad_new;

    assign done_entry = (state == FLUSH) && !init;
    assign sad_new    = vld_p1 ? acc_nxt : acc_p2;

    // Running minimum over finished blocks; ties keep the earlier candidate
    always_ff @(posedge clk) begin
        if (rst || min_clr) begin
            min_vld     <= 1'b0;
            cand_idx    <= '0;
            out_min_sad <= '1;
            out_min_idx <= '0;
            if (!rst && done_entry) begin
                min_vld     <= 1'b1;
                cand_idx    <= IDX_W'(1);
                out_min_sad <= sad_new;
            end
        end else if (done_entry) begin
            cand_idx <= cand_idx + 1'b1;
            if (!min_vld || (sad_new < out_min_sad)) begin
                min_vld     <= 1'b1;
                out_min_sad <= sad_new;
                out_min_idx <= cand_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sad_partial_par.sv
// Directed bench for sad_partial_par: default configuration (table driven),
// a wide LANES=8/BLOCK=64/WIDTH=10 instance, a single-beat BLOCK==LANES
// instance, and the minimum tracker when SAD_MIN_TRACK_EN is defined.
module tb_sad_partial_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A: defaults ----------------
    logic        a_rst = 1'b1, a_init = 1'b0, a_loaded = 1'b0, a_ack = 1'b0;
    logic [31:0] a_ori = '0, a_can = '0;
    logic        a_ready, a_done;
    logic [12:0] a_sad;
`ifdef SAD_MIN_TRACK_EN
    logic        a_min_clr = 1'b0;
    logic [12:0] a_min_sad;
    logic [7:0]  a_min_idx;
`endif

    sad_partial_par u_a (
        .clk(clk), .rst(a_rst), .init(a_init), .loaded(a_loaded), .ack(a_ack),
        .ori(a_ori), .can(a_can),
`ifdef SAD_MIN_TRACK_EN
        .min_clr(a_min_clr), .out_min_sad(a_min_sad), .out_min_idx(a_min_idx),
`endif
        .out_ready(a_ready), .out_done(a_done), .out_sad(a_sad)
    );

    // ---------------- instance B: WIDTH=10, LANES=8, BLOCK=64 ----------------
    logic        b_rst = 1'b1, b_init = 1'b0, b_loaded = 1'b0, b_ack = 1'b0;
    logic [79:0] b_ori = '0, b_can = '0;
    logic        b_ready, b_done;
    logic [15:0] b_sad;
`ifdef SAD_MIN_TRACK_EN
    logic [15:0] b_min_sad;
    logic [7:0]  b_min_idx;
`endif

    sad_partial_par #(.WIDTH(10), .LANES(8), .BLOCK(64)) u_b (
        .clk(clk), .rst(b_rst), .init(b_init), .loaded(b_loaded), .ack(b_ack),
        .ori(b_ori), .can(b_can),
`ifdef SAD_MIN_TRACK_EN
        .min_clr(1'b0), .out_min_sad(b_min_sad), .out_min_idx(b_min_idx),
`endif
        .out_ready(b_ready), .out_done(b_done), .out_sad(b_sad)
    );

    // ---------------- instance C: BLOCK == LANES ----------------
    logic        c_rst = 1'b1, c_init = 1'b0, c_loaded = 1'b0, c_ack = 1'b0;
    logic [31:0] c_ori = '0, c_can = '0;
    logic        c_ready, c_done;
    logic [9:0]  c_sad;
`ifdef SAD_MIN_TRACK_EN
    logic [9:0]  c_min_sad;
    logic [7:0]  c_min_idx;
`endif

    sad_partial_par #(.WIDTH(8), .LANES(4), .BLOCK(4)) u_c (
        .clk(clk), .rst(c_rst), .init(c_init), .loaded(c_loaded), .ack(c_ack),
        .ori(c_ori), .can(c_can),
`ifdef SAD_MIN_TRACK_EN
        .min_clr(1'b0), .out_min_sad(c_min_sad), .out_min_idx(c_min_idx),
`endif
        .out_ready(c_ready), .out_done(c_done), .out_sad(c_sad)
    );

    typedef struct {
        string       name;
        logic [31:0] o0;
        logic [31:0] c0;
        logic [31:0] o;
        logic [31:0] c;
        int          exp;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic a_start();
        a_init = 1'b1;
        tick();
        a_init = 1'b0;
    endtask

    task automatic a_beat(input logic [31:0] o, input logic [31:0] c);
        a_ori    = o;
        a_can    = c;
        a_loaded = 1'b1;
        tick();
        a_loaded = 1'b0;
    endtask

    // One 8-beat block: first beat o0/c0, the remaining seven o/c
    task automatic a_block(input string name, input logic [31:0] o0, input logic [31:0] c0,
                           input logic [31:0] o, input logic [31:0] c, input int exp);
        a_start();
        chk({name, "_ready"}, a_ready, 1);
        a_beat(o0, c0);
        for (int i = 1; i < 8; i++) a_beat(o, c);
        // one cycle after the last-beat edge: FLUSH, result not yet flagged
        chk({name, "_flush_done"}, a_done, 0);
        chk({name, "_flush_ready"}, a_ready, 0);
        tick();
        // second cycle after the last-beat edge: DONE
        chk({name, "_done"}, a_done, 1);
        chk({name, "_sad"}, a_sad, exp);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk({name, "_ack_done"}, a_done, 0);
        chk({name, "_hold_sad"}, a_sad, exp);
    endtask

    task automatic b_block(input string name, input int gaps);
        b_init = 1'b1;
        tick();
        b_init = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_ori    = {8{10'h3FF}};
            b_can    = '0;
            b_loaded = 1'b1;
            tick();
            b_loaded = 1'b0;
            if (gaps != 0 && i < 7) repeat (i % 4) tick();
        end
        chk({name, "_flush_done"}, b_done, 0);
        tick();
        chk({name, "_done"}, b_done, 1);
        chk({name, "_sad"}, b_sad, 65472);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk({name, "_ack_done"}, b_done, 0);
    endtask

    initial begin
        tbl[0] = '{"ff_vs_zero", 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 8160};
        tbl[1] = '{"equal",      32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 0};
        tbl[2] = '{"zero_vs_ff", 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 8160};
        tbl[3] = '{"diff_one",   32'h10101010, 32'h11111111, 32'h10101010, 32'h11111111, 32};
        tbl[4] = '{"mixed",      32'h01020304, 32'h04030201, 32'h01020304, 32'h04030201, 64};
        tbl[5] = '{"alternate",  32'hFF00FF00, 32'h00FF00FF, 32'hFF00FF00, 32'h00FF00FF, 8160};
        tbl[6] = '{"varied",     32'h0A141E28, 32'h28141E0A, 32'h0A141E28, 32'h28141E0A, 480};
        tbl[7] = '{"first_only", 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1020};

        repeat (2) tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        c_rst = 1'b0;

        // reset state
        chk("rst_done", a_done, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_sad", a_sad, 0);

        // loaded in IDLE is ignored
        a_beat(32'hFFFFFFFF, 32'h0);
        chk("idle_loaded_sad", a_sad, 0);
        chk("idle_loaded_done", a_done, 0);

        for (int i = 0; i < 8; i++)
            a_block(tbl[i].name, tbl[i].o0, tbl[i].c0, tbl[i].o, tbl[i].c, tbl[i].exp);

        // loaded after the result is taken leaves it unchanged
        a_beat(32'hFFFFFFFF, 32'h0);
        chk("post_idle_sad", a_sad, 1020);
        chk("post_idle_done", a_done, 0);

        // restart after three beats: stale beats must not contribute
        a_start();
        for (int i = 0; i < 3; i++) a_beat(32'hFFFFFFFF, 32'h0);
        a_block("restart", 32'h01010101, 32'h0, 32'h01010101, 32'h0, 32);

        // reset during beat 5 abandons the block
        a_start();
        for (int i = 0; i < 4; i++) a_beat(32'hFFFFFFFF, 32'h0);
        a_rst    = 1'b1;
        a_loaded = 1'b1;
        tick();
        a_rst    = 1'b0;
        a_loaded = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_beat(32'hFFFFFFFF, 32'h0);
            tick();
        end
        chk("midrst_done", a_done, 0);
        chk("midrst_sad", a_sad, 0);
        chk("midrst_ready", a_ready, 0);

        // wide instance, back-to-back then with 0..3 cycle gaps
        b_block("wide", 0);
        b_block("wide_gaps", 1);

        // single-beat block goes straight from ACC to FLUSH
        c_init = 1'b1;
        tick();
        c_init = 1'b0;
        chk("degen_ready", c_ready, 1);
        c_ori    = 32'hFFFFFFFF;
        c_can    = 32'h0;
        c_loaded = 1'b1;
        tick();
        c_loaded = 1'b0;
        chk("degen_flush", c_done, 0);
        chk("degen_ready_off", c_ready, 0);
        tick();
        chk("degen_done", c_done, 1);
        chk("degen_sad", c_sad, 1020);

`ifdef SAD_MIN_TRACK_EN
        a_min_clr = 1'b1;
        tick();
        a_min_clr = 1'b0;
        chk("minclr_sad", a_min_sad, 13'h1FFF);
        chk("minclr_idx", a_min_idx, 0);
        a_block("min50", 32'h32, 32'h0, 32'h0, 32'h0, 50);
        a_block("min20a", 32'h14, 32'h0, 32'h0, 32'h0, 20);
        a_block("min20b", 32'h14, 32'h0, 32'h0, 32'h0, 20);
        a_block("min35", 32'h23, 32'h0, 32'h0, 32'h0, 35);
        chk("min_sad", a_min_sad, 20);
        chk("min_idx", a_min_idx, 1);
        a_min_clr = 1'b1;
        tick();
        a_min_clr = 1'b0;
        a_block("min90", 32'h5A, 32'h0, 32'h0, 32'h0, 90);
        chk("min_after_clr_sad", a_min_sad, 90);
        chk("min_after_clr_idx", a_min_idx, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_partial_par.md
SAD_PARTIAL_PAR -- requirements
Module: sad_partial_par

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel bit width.
REQ-002 SHALL have parameter LANES, default 4, pixel pairs per load beat; must be a power of two, 1..16.
REQ-003 SHALL have parameter BLOCK, default 32, pixels per block; must be a multiple of LANES.
REQ-004 SHALL have port clk, input, 1, single clock, all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port init, input, 1, start or restart a block.
REQ-007 SHALL have port loaded, input, 1, ori/can beat valid this cycle.
REQ-008 SHALL have port ack, input, 1, consumer accepted the result.
REQ-009 SHALL have port ori, input, LANES*WIDTH, original pixels; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port can, input, LANES*WIDTH, candidate pixels, packed the same way as ori.
REQ-011 SHALL have port out_ready, output, 1, block accepts a loaded beat this cycle.
REQ-012 SHALL have port out_done, output, 1, out_sad valid; held until ack.
REQ-013 SHALL have port out_sad, output, SAD_W = WIDTH+clog2(BLOCK), block SAD (13 bits at defaults).

Function
REQ-014 SHALL implement FSM states IDLE, ACC, FLUSH, DONE.
REQ-015 SHALL, in any state, on init=1: clear the accumulator and beat counter, drop any in-flight beat, and enter ACC next cycle; init overrides loaded and ack.
REQ-016 SHALL assert out_ready only in ACC.
REQ-017 SHALL, in ACC with loaded=1: register the lane sum of |ori_k-can_k| (unsigned, width WIDTH+clog2(LANES)) into stage 1 and increment the beat counter.
REQ-018 SHALL add stage 1 into the SAD_W accumulator one cycle after capture, with no overflow possible by construction.
REQ-019 SHALL move from ACC to FLUSH on the accepted beat numbered BLOCK/LANES-1, then to DONE after exactly one cycle.
REQ-020 SHALL have out_done rise 2 cycles after the clock edge that samples the last beat.
REQ-021 SHALL ignore loaded outside ACC, and ignore ack outside DONE.
REQ-022 SHALL allow gaps between beats (loaded=0) in ACC; no timeout.
REQ-023 SHALL hold out_done=1 in DONE until ack=1, then go to IDLE; out_done falls in the cycle after ack.
REQ-024 SHALL hold out_sad stable from DONE entry through IDLE until the next init.
REQ-025 SHALL be degenerate-safe: with BLOCK==LANES, one beat goes ACC to FLUSH directly.

Reset
REQ-026 SHALL, on rst=1 at a clock edge: state=IDLE, accumulator=0, stage1=0, beat counter=0, out_done=0, out_ready=0, out_sad=0; rst overrides init.
REQ-027 SHALL apply reset mid-block and abandon the block with no result.

Configuration
REQ-028 SHALL support macro SAD_MIN_TRACK_EN; when defined, the block adds ports min_clr (input, 1), out_min_sad (output, SAD_W) and out_min_idx (output, 8).
REQ-029 SHALL, with SAD_MIN_TRACK_EN defined, keep a candidate counter that increments on each DONE entry and wraps from 255 to 0.
REQ-030 SHALL, with SAD_MIN_TRACK_EN defined, on DONE entry update the minimum to the new SAD and current index when no minimum is valid or SAD < min; on ties keep the earlier value.
REQ-031 SHALL, with SAD_MIN_TRACK_EN defined, have min_clr or rst clear the minimum-valid flag, the counter, out_min_sad (to all ones) and out_min_idx (to 0); min_clr coincident with a DONE entry makes that candidate the new minimum with index 0.
REQ-032 SHALL, without SAD_MIN_TRACK_EN, omit these ports and logic; all other behaviour is identical.

Structure
REQ-033 SHALL take the FSM state enum, the SAD_W/lane-sum-width helper functions and the 8-bit index width constant from a shared package, sad_pkg.
REQ-034 SHALL instantiate one sub-module, sad_lane_tree: combinational |a-b| per lane plus an adder tree, parametrised by WIDTH and LANES.

Verification
REQ-035 SHALL verify defaults, all ori=0xFF, all can=0x00, 8 beats -> out_sad=8160 (0x1FE0), out_done exactly 2 cycles after the last beat.
REQ-036 SHALL verify defaults, ori=can for all beats -> out_sad=0; ack -> out_done=0 next cycle, out_sad still 0.
REQ-037 SHALL verify init after 3 beats, then 8 fresh beats of |diff|=1 -> out_sad=32; stale beats do not contribute.
REQ-038 SHALL verify LANES=8, BLOCK=64, WIDTH=10, diff 1023 everywhere -> out_sad=65472; loaded gaps of 0-3 cycles give the same result.
REQ-039 SHALL verify rst during beat 5, then loaded pulses with no init -> out_done stays 0 and out_sad=0.
REQ-040 SHALL verify, with SAD_MIN_TRACK_EN, candidate SADs 50, 20, 20, 35 -> out_min_sad=20, out_min_idx=1; after min_clr, candidate 90 -> 90, idx 0.
